efpga_io_bridge: RTL

//  Parametrised pad-to-fabric I/O bridge between the openframe GPIO pads and eFPGA_top I/O_top/T_top.

---
 rtl/efpga_io_bridge.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/efpga_io_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : efpga_io_bridge
// Purpose  : Pad-to-fabric I/O bridge between the openframe GPIO pads and the
//            eFPGA I/O_top/T_top. Provides a per-pin runtime mode register,
//            input synchronisation, an optional glitch filter and inversion,
//            and holds every pad in a safe input state until the fabric
//            reports configuration complete.
// Ports    : clk, reset (async, active-high)
//            io_in/io_out/io_oeb   pad side (oeb active-low: 1 = pad is input)
//            fab_I/fab_T/fab_O     fabric side (T=1: fabric not driving)
//            fab_ready             fabric config done (asynchronous source)
//            cfg_we/cfg_re/cfg_addr/cfg_wdata   mode register access port
//            cfg_rdata/cfg_ack/cfg_err          access response, 1 cycle later
//            Mode register per pin: {filt_en, inv, mode[1:0]}
//              mode 00 SAFE, 01 FABRIC, 10 FORCE_OUT, 11 INPUT
// Revision : 1.0  initial release
// ============================================================================
module efpga_io_bridge #(
    parameter int NUM_IO      = 28,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    input  logic [NUM_IO-1:0] fab_I,
    input  logic [NUM_IO-1:0] fab_T,
    output logic [NUM_IO-1:0] fab_O,
    input  logic              fab_ready,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3:0]        cfg_wdata,
    output logic [3:0]        cfg_rdata,
    output logic              cfg_ack,
    output logic              cfg_err
);

    // The counter only has to reach FILT_LEN-1: the edge on which it would
    // hit FILT_LEN is the edge on which the filtered value is updated.
    localparam int                 c_CNT_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(FILT_LEN - 1);
    localparam logic [1:0]         c_MODE_FAB   = 2'b01;
    localparam logic [1:0]         c_MODE_FORCE = 2'b10;
    localparam int                 c_BIT_FILT   = 3;
    localparam int                 c_BIT_INV    = 2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                rdy_meta_q, rdy_meta_d;
    logic                rdy_s_q,    rdy_s_d;
    logic [3:0]          mode_q [NUM_IO];
    logic [3:0]          mode_d [NUM_IO];
    logic [NUM_IO-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_IO-1:0]   sync_d [SYNC_STAGES];
    logic [c_CNT_W-1:0]  cnt_q  [NUM_IO];
    logic [c_CNT_W-1:0]  cnt_d  [NUM_IO];
    logic [NUM_IO-1:0]   filt_q,   filt_d;
    logic [NUM_IO-1:0]   fab_o_q,  fab_o_d;
    logic [NUM_IO-1:0]   io_out_q, io_out_d;
    logic [NUM_IO-1:0]   io_oeb_q, io_oeb_d;
    logic [3:0]          cfg_rdata_q, cfg_rdata_d;
    logic                cfg_ack_q,   cfg_ack_d;
    logic                cfg_err_q,   cfg_err_d;

    logic                w_addr_ok;
    logic                w_wr;
    logic                w_rd;
    logic [NUM_IO-1:0]   w_pin_wr;
    logic [NUM_IO-1:0]   w_sync;

    // ------------------------------------------------------------------
    // Config port: write wins over a simultaneous read, the read is lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_addr_ok   = (32'(cfg_addr) < 32'(NUM_IO));
        w_wr        = cfg_we & w_addr_ok;
        w_rd        = cfg_re & ~cfg_we & w_addr_ok;
        cfg_ack_d   = (cfg_we | cfg_re) & w_addr_ok;
        cfg_err_d   = (cfg_we | cfg_re) & ~w_addr_ok;
        cfg_rdata_d = cfg_rdata_q;
        if (w_rd) begin
            cfg_rdata_d = mode_q[cfg_addr];
        end
    end

    always_comb begin
        w_pin_wr = '0;
        for (int p = 0; p < NUM_IO; p++) begin
            w_pin_wr[p] = w_wr && (cfg_addr == ADDR_W'(p));
        end
    end

    // ------------------------------------------------------------------
    // Ready synchroniser and input synchroniser chain
    // ------------------------------------------------------------------
    always_comb begin
        rdy_meta_d = fab_ready;
        rdy_s_d    = rdy_meta_q;
        sync_d[0]  = io_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign w_sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Per-pin mode, glitch filter, inversion and pad drive
    // ------------------------------------------------------------------
    always_comb begin
        filt_d   = filt_q;
        fab_o_d  = '0;
        io_out_d = '0;
        io_oeb_d = '1;
        for (int p = 0; p < NUM_IO; p++) begin
            mode_d[p] = w_pin_wr[p] ? cfg_wdata : mode_q[p];
            cnt_d[p]  = '0;

            // With the filter disabled (or on any rewrite of the pin) the
            // filtered value simply tracks the synchronised input, so that
            // enabling the filter starts from the current pin level.
            if (!mode_q[p][c_BIT_FILT] || w_pin_wr[p]) begin
                filt_d[p] = w_sync[p];
            end else if (w_sync[p] != filt_q[p]) begin
                if (cnt_q[p] == c_CNT_LAST) begin
                    filt_d[p] = w_sync[p];
                end else begin
                    cnt_d[p] = cnt_q[p] + 1'b1;
                end
            end

            fab_o_d[p] = (mode_q[p][c_BIT_FILT] ? filt_q[p] : w_sync[p])
                         ^ mode_q[p][c_BIT_INV];

            // Until the fabric is configured every pin is held SAFE.
            if (rdy_s_q) begin
                if (mode_q[p][1:0] == c_MODE_FAB) begin
                    io_out_d[p] = fab_I[p];
                    io_oeb_d[p] = fab_T[p];
                end else if (mode_q[p][1:0] == c_MODE_FORCE) begin
                    io_out_d[p] = fab_I[p];
                    io_oeb_d[p] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_meta_q  <= 1'b0;
            rdy_s_q     <= 1'b0;
            filt_q      <= '0;
            fab_o_q     <= '0;
            io_out_q    <= '0;
            io_oeb_q    <= '1;
            cfg_rdata_q <= '0;
            cfg_ack_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int p = 0; p < NUM_IO; p++) begin
                mode_q[p] <= '0;
                cnt_q[p]  <= '0;
            end
        end else begin
            rdy_meta_q  <= rdy_meta_d;
            rdy_s_q     <= rdy_s_d;
            filt_q      <= filt_d;
            fab_o_q     <= fab_o_d;
            io_out_q    <= io_out_d;
            io_oeb_q    <= io_oeb_d;
            cfg_rdata_q <= cfg_rdata_d;
            cfg_ack_q   <= cfg_ack_d;
            cfg_err_q   <= cfg_err_d;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int p = 0; p < NUM_IO; p++) begin
                mode_q[p] <= mode_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
        end
    end

    assign io_out    = io_out_q;
    assign io_oeb    = io_oeb_q;
    assign fab_O     = fab_o_q;
    assign cfg_rdata = cfg_rdata_q;
    assign cfg_ack   = cfg_ack_q;
    assign cfg_err   = cfg_err_q;

endmodule
`default_nettype wire
